dot_accum: RTL and testbench

- Downstream consumer of the combinational dot-product stage.
- That stage produces a 6-bit popcount of (vector_a & vector_b), range 0..32.
- dot_accum accepts one such result per handshake, sums FRAME_LEN results into a frame total, then holds the total until the sink takes it.
- Provides the valid/ready buffering between the combinational core and the later sequential datapath.

---
 rtl/dot_pkg.sv | 11 +
 rtl/dot_sat_add.sv | 24 ++
 rtl/dot_accum.sv | 97 +++++++++
 tb/tb_dot_accum.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product stage and its downstream accumulator.
package dot_pkg;
  localparam int DOT_RES_W = 6;
  localparam int DOT_VEC_W = 32;

  typedef enum logic {ACC, HOLD} state_e;

  function automatic int sat_sum_w(input int acc_w);
    return acc_w + 1;
  endfunction
endpackage

// File: rtl/dot_sat_add.sv
// Combinational ACC_W-bit + DOT_RES_W-bit unsigned adder that clamps to all-ones.
module dot_sat_add
  import dot_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]     acc_i,
  input  logic [DOT_RES_W-1:0] add_i,
  output logic [ACC_W-1:0]     sum_o,
  output logic                 ovf_o
);
  localparam int SUM_W = sat_sum_w(ACC_W);

  logic [SUM_W-1:0] wide;

  // The carry out of the widened sum is exactly the overflow indication.
  function automatic logic [ACC_W-1:0] saturate(input logic [SUM_W-1:0] s);
    return s[SUM_W-1] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign wide  = {1'b0, acc_i} + SUM_W'(add_i);
  assign sum_o = saturate(wide);
  assign ovf_o = wide[SUM_W-1];
endmodule

// File: rtl/dot_accum.sv
// Sums FRAME_LEN dot-product results per frame and holds the total for the sink.
// Define DOT_ACCUM_MAX_EN to add out_max, the largest element of the frame.
module dot_accum
  import dot_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DOT_RES_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
`ifdef DOT_ACCUM_MAX_EN
  output logic [DOT_RES_W-1:0] out_max,
`endif
  output logic                 out_ovf
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sat_sum;
  logic             sat_ovf;
`ifdef DOT_ACCUM_MAX_EN
  logic [DOT_RES_W-1:0] max_q, max_d;
`endif

  dot_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc_i (acc_q),
    .add_i (in_data),
    .sum_o (sat_sum),
    .ovf_o (sat_ovf)
  );

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
`ifdef DOT_ACCUM_MAX_EN
  assign out_max   = max_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef DOT_ACCUM_MAX_EN
    max_d   = max_q;
`endif
    // clear and frame exit both restart an empty frame in ACC
    if (clear || (state_q == HOLD && out_ready)) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef DOT_ACCUM_MAX_EN
      max_d   = '0;
`endif
    end else if (state_q == ACC && in_valid) begin
      acc_d = sat_sum;
      ovf_d = ovf_q | sat_ovf;
      cnt_d = cnt_q + CNT_W'(1);
`ifdef DOT_ACCUM_MAX_EN
      if (in_data > max_q) max_d = in_data;
`endif
      if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef DOT_ACCUM_MAX_EN
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef DOT_ACCUM_MAX_EN
      max_q   <= max_d;
`endif
    end
  end
endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: a wide (ACC_W=12) and a narrow (ACC_W=6) instance share stimulus.
module tb_dot_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic        a_iready, a_ovalid, a_oovf;
  logic [11:0] a_sum;
  logic        b_iready, b_ovalid, b_oovf;
  logic [5:0]  b_sum;
`ifdef DOT_ACCUM_MAX_EN
  logic [5:0]  a_max, b_max;
`endif

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic        ovf;
    logic [5:0]  mx;
    logic [11:0] sum;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int macc[2];
  bit movf[2];
  int mmax;
  int mcnt;

  always #5 clk = ~clk;

  dot_accum #(.FRAME_LEN(4), .ACC_W(12)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_iready),
    .in_data(in_data), .out_valid(a_ovalid), .out_ready(out_ready), .out_sum(a_sum),
`ifdef DOT_ACCUM_MAX_EN
    .out_max(a_max),
`endif
    .out_ovf(a_oovf)
  );

  dot_accum #(.FRAME_LEN(4), .ACC_W(6)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_iready),
    .in_data(in_data), .out_valid(b_ovalid), .out_ready(out_ready), .out_sum(b_sum),
`ifdef DOT_ACCUM_MAX_EN
    .out_max(b_max),
`endif
    .out_ovf(b_oovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    macc[0] = 0; macc[1] = 0;
    movf[0] = 1'b0; movf[1] = 1'b0;
    mmax = 0;
    mcnt = 0;
  endtask

  task automatic model_accept(input int d);
    int lim;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      lim = (i == 0) ? 4095 : 63;
      if (macc[i] + d > lim) begin
        macc[i] = lim;
        movf[i] = 1'b1;
      end else begin
        macc[i] = macc[i] + d;
      end
    end
    if (d > mmax) mmax = d;
    mcnt++;
    if (mcnt == 4) begin
      e.sum = 12'(macc[0]); e.ovf = movf[0]; e.mx = 6'(mmax);
      qa.push_back(e);
      e.sum = 12'(macc[1]); e.ovf = movf[1];
      qb.push_back(e);
      model_reset();
    end
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = 6'(d);
    chk("in_ready_a", 32'(a_iready), 1);
    chk("in_ready_b", 32'(b_iready), 1);
    model_accept(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic take();
    exp_t ea, eb;
    chk("out_valid_a", 32'(a_ovalid), 1);
    chk("out_valid_b", 32'(b_ovalid), 1);
    chk("sb_pending_a", 32'(qa.size() > 0), 1);
    chk("sb_pending_b", 32'(qb.size() > 0), 1);
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("out_sum_a", 32'(a_sum), 32'(ea.sum));
      chk("out_ovf_a", 32'(a_oovf), 32'(ea.ovf));
      chk("out_sum_b", 32'(b_sum), 32'(eb.sum[5:0]));
      chk("out_ovf_b", 32'(b_oovf), 32'(eb.ovf));
`ifdef DOT_ACCUM_MAX_EN
      chk("out_max_a", 32'(a_max), 32'(ea.mx));
      chk("out_max_b", 32'(b_max), 32'(eb.mx));
`endif
    end
    // an input offered in the take cycle must not be consumed
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 6'd33;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("exit_valid_a", 32'(a_ovalid), 0);
    chk("exit_ready_a", 32'(a_iready), 1);
    chk("exit_ready_b", 32'(b_iready), 1);
    chk("exit_sum_a", 32'(a_sum), 0);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_in_ready", 32'(a_iready), 1);
    chk("rst_out_valid", 32'(a_ovalid), 0);
    chk("rst_out_sum", 32'(a_sum), 0);
    chk("rst_out_ovf", 32'(b_oovf), 0);
    step();
    rst_n = 1'b1;
    step();

    // basic frame with back-pressure
    send(1); send(3); send(1); send(3);
    chk("hold_in_ready_a", 32'(a_iready), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 6'd5;
      chk("bp_in_ready", 32'(a_iready), 0);
      chk("bp_out_valid", 32'(a_ovalid), 1);
      chk("bp_out_sum", 32'(a_sum), 8);
      step();
    end
    in_valid = 1'b0;
    take();

    // saturation on the narrow instance, then a clean frame
    send(32); send(32); send(5); send(0);
    take();
    send(1); send(2); send(3); send(4);
    take();

    // clear mid-frame discards the partial sum and the cycle's input
    send(7); send(9);
    in_valid = 1'b1; in_data = 6'd20; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    chk("clr_out_valid", 32'(a_ovalid), 0);
    chk("clr_in_ready", 32'(a_iready), 1);
    chk("clr_sum_a", 32'(a_sum), 0);
    send(2); send(2); send(2); send(2);
    take();

    // clear in HOLD drops the pending frame
    send(1); send(1); send(1); send(1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    void'(qa.pop_back());
    void'(qb.pop_back());
    chk("clr_hold_valid_a", 32'(a_ovalid), 0);
    chk("clr_hold_valid_b", 32'(b_ovalid), 0);
    chk("clr_hold_ready", 32'(a_iready), 1);

    // frame maximum
    send(4); send(17); send(2); send(9);
    take();

    // asynchronous reset while in HOLD
    send(40); send(40); send(1); send(1);
    chk("pre_rst_valid", 32'(a_ovalid), 1);
    chk("pre_rst_ovf_b", 32'(b_oovf), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_a", 32'(a_ovalid), 0);
    chk("arst_valid_b", 32'(b_ovalid), 0);
    chk("arst_sum_a", 32'(a_sum), 0);
    chk("arst_ovf_b", 32'(b_oovf), 0);
    chk("arst_in_ready", 32'(a_iready), 1);
    qa.delete();
    qb.delete();
    model_reset();
    #1 rst_n = 1'b1;
    step();

    send(5); send(5); send(5); send(5);
    take();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
